mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 216 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one main-memory port between an I-cache miss, a D-cache miss and a
// D-cache write-through store.  A store is always served first as a single
// write cycle.  A miss is served as a block fill: WORDS reads issued on
// consecutive cycles, then each returned word is written into the requesting
// cache one cycle after the memory presents it.  When both misses wait
// together, the side that was not filled last wins.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   i_miss, i_miss_addr             I-cache miss request (level) + byte address
//   d_miss, d_miss_addr             D-cache miss request (level) + byte address
//   d_wr, d_wr_addr, d_wr_data      D-cache store request (level) + addr/data
//   mem_en, mem_wr                  memory request strobe / write select
//   mem_addr, mem_data_out          memory address / write data (hold when idle)
//   mem_data_in, mem_data_valid     memory read data, returned in issue order
//   fill_data, fill_word            registered fill word and its block index
//   i_fill_we, d_fill_we            fill write enables into each cache
//   i_fill_done, d_fill_done        one-cycle pulse with the last fill write
//   d_wr_ack                        one-cycle pulse in the write cycle
//   i_fsm_busy, d_fsm_busy          stall requests to the pipeline hazard logic
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int WORDS = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_miss,
  input  logic [15:0]              i_miss_addr,
  input  logic                     d_miss,
  input  logic [15:0]              d_miss_addr,
  input  logic                     d_wr,
  input  logic [15:0]              d_wr_addr,
  input  logic [15:0]              d_wr_data,
  output logic                     mem_en,
  output logic                     mem_wr,
  output logic [15:0]              mem_addr,
  output logic [15:0]              mem_data_out,
  input  logic [15:0]              mem_data_in,
  input  logic                     mem_data_valid,
  output logic [15:0]              fill_data,
  output logic [$clog2(WORDS)-1:0] fill_word,
  output logic                     i_fill_we,
  output logic                     d_fill_we,
  output logic                     i_fill_done,
  output logic                     d_fill_done,
  output logic                     d_wr_ack,
  output logic                     i_fsm_busy,
  output logic                     d_fsm_busy
);

  localparam int WL = $clog2(WORDS);
  // Counters carry one extra bit: the MSB set means "all WORDS handled".
  localparam int CW = WL + 1;
  // Clears the byte-within-block bits of an address.
  localparam logic [15:0] BASE_MASK = ~16'(2 * WORDS - 1);

  typedef enum logic [1:0] {IDLE, WRITE, FILL_I, FILL_D} state_t;

  state_t        state, state_nxt;
  logic          last_fill_d;   // 0: I side filled last (reset value), 1: D side
  logic [CW-1:0] issue_cnt;
  logic [CW-1:0] rcv_cnt;
  logic [15:0]   base_addr;
  logic [15:0]   wr_addr_q;
  logic [15:0]   wr_data_q;
  logic [15:0]   addr_hold;
  logic [15:0]   data_hold;
  logic          fill_we_q;
  logic          in_fill;
  logic          issuing;
  logic          last_write;

  assign in_fill    = (state == FILL_I) || (state == FILL_D);
  assign issuing    = in_fill && !issue_cnt[WL];
  assign last_write = fill_we_q && (fill_word == WL'(WORDS - 1));

  // Stall requests are plain combinational functions of the request levels
  // and the completion pulses, so the pipeline releases in the done cycle.
  assign i_fsm_busy = i_miss && !i_fill_done;
  assign d_fsm_busy = (d_miss || d_wr) && !d_fill_done && !d_wr_ack;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state is always written with <= so every register samples
  // the pre-edge value of every other register, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and memory / cache outputs
  // ---------------------------------------------------------------------------
  // NOTE: every signal this block drives gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_nxt    = state;
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = addr_hold;
    mem_data_out = data_hold;
    d_wr_ack     = 1'b0;
    i_fill_we    = 1'b0;
    d_fill_we    = 1'b0;
    i_fill_done  = 1'b0;
    d_fill_done  = 1'b0;

    unique case (state)
      IDLE: begin
        if (d_wr) begin
          state_nxt = WRITE;
        end else if (i_miss && d_miss) begin
          state_nxt = last_fill_d ? FILL_I : FILL_D;
        end else if (i_miss) begin
          state_nxt = FILL_I;
        end else if (d_miss) begin
          state_nxt = FILL_D;
        end
      end

      WRITE: begin
        mem_en       = 1'b1;
        mem_wr       = 1'b1;
        mem_addr     = wr_addr_q;
        mem_data_out = wr_data_q;
        d_wr_ack     = 1'b1;
        state_nxt    = IDLE;
      end

      FILL_I, FILL_D: begin
        mem_en = issuing;
        if (issuing) begin
          // base has its low bits cleared, so OR-ing the offset never carries.
          mem_addr = base_addr | 16'({issue_cnt[WL-1:0], 1'b0});
        end
        if (state == FILL_I) begin
          i_fill_we   = fill_we_q;
          i_fill_done = last_write;
        end else begin
          d_fill_we   = fill_we_q;
          d_fill_done = last_write;
        end
        if (last_write) begin
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: grant latches, issue/receive counters, fill register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt   <= '0;
      rcv_cnt     <= '0;
      base_addr   <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      addr_hold   <= '0;
      data_hold   <= '0;
      fill_we_q   <= 1'b0;
      fill_data   <= '0;
      fill_word   <= '0;
      last_fill_d <= 1'b0;
    end else begin
      // Memory address/data hold whatever was last presented.
      addr_hold <= mem_addr;
      data_hold <= mem_data_out;
      fill_we_q <= 1'b0;

      if (state == IDLE) begin
        issue_cnt <= '0;
        rcv_cnt   <= '0;
        case (state_nxt)
          WRITE: begin
            wr_addr_q <= d_wr_addr;
            wr_data_q <= d_wr_data;
          end
          FILL_I:  base_addr <= i_miss_addr & BASE_MASK;
          FILL_D:  base_addr <= d_miss_addr & BASE_MASK;
          default: ;
        endcase
      end

      if (issuing) begin
        issue_cnt <= issue_cnt + CW'(1);
      end

      // Responses beyond the block size, or outside a fill, are dropped.
      if (in_fill && mem_data_valid && !rcv_cnt[WL]) begin
        fill_data <= mem_data_in;
        fill_word <= rcv_cnt[WL-1:0];
        fill_we_q <= 1'b1;
        rcv_cnt   <= rcv_cnt + CW'(1);
      end

      if (i_fill_done) begin
        last_fill_d <= 1'b0;
      end
      if (d_fill_done) begin
        last_fill_d <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Self-checking bench for mem_arbiter (WORDS=8).  A tick() task advances one
// cycle at the falling edge and, in one process, logs DUT activity, models a
// fixed-latency main memory (LAT cycles, data = addr ^ 16'hA5C3) and drops
// each cache request when its completion pulse is seen.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int WORDS = 8;
  localparam int LAT   = 4;
  localparam int WL    = $clog2(WORDS);

  logic          clk;
  logic          rst_n;
  logic          i_miss;
  logic [15:0]   i_miss_addr;
  logic          d_miss;
  logic [15:0]   d_miss_addr;
  logic          d_wr;
  logic [15:0]   d_wr_addr;
  logic [15:0]   d_wr_data;
  logic          mem_en;
  logic          mem_wr;
  logic [15:0]   mem_addr;
  logic [15:0]   mem_data_out;
  logic [15:0]   mem_data_in;
  logic          mem_data_valid;
  logic [15:0]   fill_data;
  logic [WL-1:0] fill_word;
  logic          i_fill_we;
  logic          d_fill_we;
  logic          i_fill_done;
  logic          d_fill_done;
  logic          d_wr_ack;
  logic          i_fsm_busy;
  logic          d_fsm_busy;

  mem_arbiter #(.WORDS(WORDS)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_miss         (i_miss),
    .i_miss_addr    (i_miss_addr),
    .d_miss         (d_miss),
    .d_miss_addr    (d_miss_addr),
    .d_wr           (d_wr),
    .d_wr_addr      (d_wr_addr),
    .d_wr_data      (d_wr_data),
    .mem_en         (mem_en),
    .mem_wr         (mem_wr),
    .mem_addr       (mem_addr),
    .mem_data_out   (mem_data_out),
    .mem_data_in    (mem_data_in),
    .mem_data_valid (mem_data_valid),
    .fill_data      (fill_data),
    .fill_word      (fill_word),
    .i_fill_we      (i_fill_we),
    .d_fill_we      (d_fill_we),
    .i_fill_done    (i_fill_done),
    .d_fill_done    (d_fill_done),
    .d_wr_ack       (d_wr_ack),
    .i_fsm_busy     (i_fsm_busy),
    .d_fsm_busy     (d_fsm_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;
  int cyc;
  int c0;
  logic busy_ok;

  // Activity logs (cycle numbers, addresses, data)
  int rd_cyc[$];
  int rd_adr[$];
  int wr_cyc[$];
  int wr_adr[$];
  int wr_dat[$];
  int ack_cyc[$];
  int iwe_word[$];
  int iwe_data[$];
  int dwe_word[$];
  int dwe_data[$];
  int idone_cyc[$];
  int ddone_cyc[$];

  // Memory model pipeline
  logic        pv [0:LAT];
  logic [15:0] pa [0:LAT];
  logic        inject;
  logic        extra_on_done;

  typedef struct {
    logic        d_wr;
    logic        i_miss;
    logic        d_miss;
    logic        exp_ibusy;
    logic        exp_dbusy;
    logic        exp_wr;
    logic [15:0] exp_addr;
    logic [15:0] exp_dout;
  } arb_vec_t;

  arb_vec_t vecs [6];

  function automatic logic [15:0] mdata(input logic [15:0] a);
    return a ^ 16'hA5C3;
  endfunction

  function automatic int q_at(input int q[$], input int idx);
    return (idx < q.size()) ? q[idx] : -1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    rd_cyc.delete();   rd_adr.delete();
    wr_cyc.delete();   wr_adr.delete();   wr_dat.delete();  ack_cyc.delete();
    iwe_word.delete(); iwe_data.delete();
    dwe_word.delete(); dwe_data.delete();
    idone_cyc.delete(); ddone_cyc.delete();
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    // monitor
    if (mem_en && mem_wr) begin
      wr_cyc.push_back(cyc);
      wr_adr.push_back(int'(mem_addr));
      wr_dat.push_back(int'(mem_data_out));
    end
    if (mem_en && !mem_wr) begin
      rd_cyc.push_back(cyc);
      rd_adr.push_back(int'(mem_addr));
    end
    if (d_wr_ack)    ack_cyc.push_back(cyc);
    if (i_fill_we) begin
      iwe_word.push_back(int'(fill_word));
      iwe_data.push_back(int'(fill_data));
    end
    if (d_fill_we) begin
      dwe_word.push_back(int'(fill_word));
      dwe_data.push_back(int'(fill_data));
    end
    if (i_fill_done) idone_cyc.push_back(cyc);
    if (d_fill_done) ddone_cyc.push_back(cyc);
    // memory: a read seen in cycle c returns valid during cycle c+LAT
    for (int j = LAT; j > 0; j--) begin
      pv[j] = pv[j-1];
      pa[j] = pa[j-1];
    end
    pv[0] = rst_n && mem_en && !mem_wr;
    pa[0] = mem_addr;
    if (!rst_n) begin
      for (int j = 0; j <= LAT; j++) pv[j] = 1'b0;
    end
    mem_data_valid = pv[LAT];
    mem_data_in    = pv[LAT] ? mdata(pa[LAT]) : 16'h0000;
    if (inject || (extra_on_done && (i_fill_done || d_fill_done))) begin
      mem_data_valid = 1'b1;
      mem_data_in    = 16'hDEAD;
      inject         = 1'b0;
      extra_on_done  = 1'b0;
    end
    // cache side: requests drop once completed
    if (i_fill_done) i_miss = 1'b0;
    if (d_fill_done) d_miss = 1'b0;
    if (d_wr_ack)    d_wr   = 1'b0;
  endtask

  task automatic do_reset();
    i_miss = 1'b0;
    d_miss = 1'b0;
    d_wr   = 1'b0;
    rst_n  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    clear_logs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    rst_n  = 1'b0;
    i_miss = 1'b0;  i_miss_addr = 16'h1236;
    d_miss = 1'b0;  d_miss_addr = 16'h4568;
    d_wr   = 1'b0;  d_wr_addr   = 16'h00A0;  d_wr_data = 16'hBEEF;
    mem_data_in = 16'h0000;  mem_data_valid = 1'b0;
    inject = 1'b0;  extra_on_done = 1'b0;
    for (int j = 0; j <= LAT; j++) begin
      pv[j] = 1'b0;
      pa[j] = 16'h0000;
    end

    vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h1230, 16'h0000};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h4560, 16'h0000};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h00A0, 16'hBEEF};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'h4560, 16'h0000};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h00A0, 16'hBEEF};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h00A0, 16'hBEEF};

    // ---- reset state
    tick();
    #1;
    check("rst_ctrl", int'({mem_en, mem_wr, i_fill_we, d_fill_we, i_fill_done,
                            d_fill_done, d_wr_ack, i_fsm_busy, d_fsm_busy}), 0);
    check("rst_addr", int'(mem_addr), 0);
    check("rst_dout", int'(mem_data_out), 0);
    check("rst_fill_data", int'(fill_data), 0);
    check("rst_fill_word", int'(fill_word), 0);

    // ---- arbitration table: busy in IDLE, first granted cycle
    for (int i = 0; i < 6; i++) begin
      do_reset();
      tick();
      d_wr   = vecs[i].d_wr;
      i_miss = vecs[i].i_miss;
      d_miss = vecs[i].d_miss;
      #1;
      check($sformatf("vec%0d_ibusy", i), int'(i_fsm_busy), int'(vecs[i].exp_ibusy));
      check($sformatf("vec%0d_dbusy", i), int'(d_fsm_busy), int'(vecs[i].exp_dbusy));
      check($sformatf("vec%0d_idle_en", i), int'(mem_en), 0);
      tick();
      check($sformatf("vec%0d_en", i), int'(mem_en), 1);
      check($sformatf("vec%0d_wr", i), int'(mem_wr), int'(vecs[i].exp_wr));
      check($sformatf("vec%0d_ack", i), int'(d_wr_ack), int'(vecs[i].exp_wr));
      check($sformatf("vec%0d_addr", i), int'(mem_addr), int'(vecs[i].exp_addr));
      check($sformatf("vec%0d_dout", i), int'(mem_data_out), int'(vecs[i].exp_dout));
    end

    // ---- request withdrawn before its grant edge: no traffic
    do_reset();
    tick();
    i_miss = 1'b1;
    d_wr   = 1'b1;
    #1;
    check("drop_busy", int'({i_fsm_busy, d_fsm_busy}), 3);
    #2;
    i_miss = 1'b0;
    d_wr   = 1'b0;
    for (int n = 0; n < 6; n++) tick();
    check("drop_traffic", rd_adr.size() + wr_adr.size(), 0);

    // ---- single I miss at 0x1236
    do_reset();
    i_miss_addr = 16'h1236;
    tick();
    i_miss = 1'b1;
    c0 = cyc;
    for (int n = 0; n < 100 && idone_cyc.size() == 0; n++) tick();
    for (int n = 0; n < 4; n++) tick();
    check("a_rd_cnt", rd_adr.size(), WORDS);
    for (int k = 0; k < WORDS; k++)
      check($sformatf("a_rd_addr%0d", k), q_at(rd_adr, k), 16'h1230 + 2 * k);
    check("a_rd_first_cyc", q_at(rd_cyc, 0), c0 + 1);
    check("a_rd_span", q_at(rd_cyc, WORDS - 1) - q_at(rd_cyc, 0), WORDS - 1);
    check("a_iwe_cnt", iwe_word.size(), WORDS);
    for (int k = 0; k < WORDS; k++) begin
      check($sformatf("a_word%0d", k), q_at(iwe_word, k), k);
      check($sformatf("a_data%0d", k), q_at(iwe_data, k), int'(mdata(16'(16'h1230 + 2 * k))));
    end
    check("a_dwe_cnt", dwe_word.size(), 0);
    check("a_done_cnt", idone_cyc.size(), 1);
    check("a_latency", q_at(idone_cyc, 0) - c0, WORDS + LAT + 1);

    // ---- simultaneous misses: D first on every pair while I filled last
    do_reset();
    for (int p = 0; p < 4; p++) begin
      clear_logs();
      tick();
      i_miss = 1'b1;
      d_miss = 1'b1;
      for (int n = 0; n < 200 && (idone_cyc.size() == 0 || ddone_cyc.size() == 0); n++) tick();
      check($sformatf("rr%0d_dones", p), idone_cyc.size() + ddone_cyc.size(), 2);
      check($sformatf("rr%0d_d_first", p),
            int'(q_at(ddone_cyc, 0) >= 0 && q_at(ddone_cyc, 0) < q_at(idone_cyc, 0)), 1);
      check($sformatf("rr%0d_rd0", p), q_at(rd_adr, 0), 16'h4560);
      check($sformatf("rr%0d_rd8", p), q_at(rd_adr, WORDS), 16'h1230);
    end
    // after a lone D fill the next tie goes to I
    clear_logs();
    tick();
    d_miss = 1'b1;
    for (int n = 0; n < 100 && ddone_cyc.size() == 0; n++) tick();
    clear_logs();
    tick();
    i_miss = 1'b1;
    d_miss = 1'b1;
    for (int n = 0; n < 200 && (idone_cyc.size() == 0 || ddone_cyc.size() == 0); n++) tick();
    check("rr_after_d_i_first",
          int'(q_at(idone_cyc, 0) >= 0 && q_at(idone_cyc, 0) < q_at(ddone_cyc, 0)), 1);

    // ---- store raised during FILL_I waits for the fill
    do_reset();
    tick();
    i_miss = 1'b1;
    tick(); tick(); tick();
    d_wr = 1'b1;
    busy_ok = 1'b1;
    for (int n = 0; n < 100 && wr_cyc.size() == 0; n++) begin
      #1;
      if (!d_fsm_busy) busy_ok = 1'b0;
      tick();
    end
    check("w_busy_held", int'(busy_ok), 1);
    check("w_addr", q_at(wr_adr, 0), 16'h00A0);
    check("w_data", q_at(wr_dat, 0), 16'hBEEF);
    check("w_after_done", q_at(wr_cyc, 0) - q_at(idone_cyc, 0), 2);
    check("w_ack_cyc", q_at(ack_cyc, 0), q_at(wr_cyc, 0));
    for (int n = 0; n < 3; n++) tick();
    #1;
    check("w_cnt", wr_cyc.size() + 16 * ack_cyc.size(), 17);
    check("w_busy_after", int'(d_fsm_busy), 0);
    check("w_fill_reads", rd_adr.size(), WORDS);

    // ---- store and D miss together: WRITE, then FILL_D
    do_reset();
    tick();
    d_wr   = 1'b1;
    d_miss = 1'b1;
    c0 = cyc;
    for (int n = 0; n < 100 && ddone_cyc.size() == 0; n++) tick();
    check("e_wr_cyc", q_at(wr_cyc, 0), c0 + 1);
    check("e_rd_cyc", q_at(rd_cyc, 0), c0 + 3);
    check("e_rd_addr", q_at(rd_adr, 0), 16'h4560);
    check("e_dwe_cnt", dwe_word.size(), WORDS);
    check("e_done_cyc", q_at(ddone_cyc, 0) - c0, WORDS + LAT + 3);

    // ---- asynchronous reset after 3 fill writes, then refetch
    do_reset();
    tick();
    i_miss = 1'b1;
    for (int n = 0; n < 100 && iwe_word.size() < 3; n++) tick();
    rst_n = 1'b0;
    #1;
    check("r_ctrl_zero", int'({mem_en, mem_wr, i_fill_we, d_fill_we,
                               i_fill_done, d_fill_done, d_wr_ack}), 0);
    check("r_addr_zero", int'(mem_addr), 0);
    check("r_fill_zero", int'({fill_data, 4'(fill_word)}), 0);
    tick();
    tick();
    check("r_no_done", idone_cyc.size(), 0);
    clear_logs();
    rst_n = 1'b1;
    c0 = cyc;
    for (int n = 0; n < 100 && idone_cyc.size() == 0; n++) tick();
    check("r_rd_cnt", rd_adr.size(), WORDS);
    check("r_rd_first", q_at(rd_adr, 0), 16'h1230);
    check("r_rd_last", q_at(rd_adr, WORDS - 1), 16'h123E);
    check("r_word0", q_at(iwe_word, 0), 0);
    check("r_iwe_cnt", iwe_word.size(), WORDS);
    check("r_latency", q_at(idone_cyc, 0) - c0, WORDS + LAT + 1);

    // ---- spurious valid in IDLE and a 9th valid in the done cycle
    do_reset();
    tick();
    inject = 1'b1;
    tick();
    tick();
    tick();
    check("s_idle_quiet", iwe_word.size() + dwe_word.size() + rd_adr.size(), 0);
    i_miss = 1'b1;
    extra_on_done = 1'b1;
    for (int n = 0; n < 100 && idone_cyc.size() == 0; n++) tick();
    for (int n = 0; n < 3; n++) tick();
    check("s_iwe_cnt", iwe_word.size(), WORDS);
    check("s_data0", q_at(iwe_data, 0), int'(mdata(16'h1230)));
    check("s_done_cnt", idone_cyc.size(), 1);
    check("s_dwe_none", dwe_word.size(), 0);
    check("s_idle_en", int'(mem_en), 0);
    d_miss = 1'b1;
    for (int n = 0; n < 100 && ddone_cyc.size() == 0; n++) tick();
    check("s_d_word0", q_at(dwe_word, 0), 0);
    check("s_d_data0", q_at(dwe_data, 0), int'(mdata(16'h4560)));
    check("s_d_cnt", dwe_word.size(), WORDS);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
